// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and frame constants for the boot loader
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - big-endian packer, four bytes into one 32-bit word
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] acc;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      acc      <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      acc      <= {acc[15:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The fourth byte is merged combinationally so the parent can register the word on the same edge.
  assign word       = {acc, byte_in};
  assign word_valid = shift && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed byte frame into instruction memory, then releases the cpu
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_boot_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] ST_LEN_HI = LEN_HI;
  localparam logic [2:0] ST_LEN_LO = LEN_LO;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_DONE   = DONE;
  localparam logic [2:0] ST_ERR    = ERR;

  logic [2:0]      state;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [ADDR_W:0] word_cnt;

  logic        xfer;
  logic        reload;
  logic [15:0] n_new;
  logic        n_bad;
  logic        last_word;
  logic [31:0] pk_word;
  logic        pk_valid;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign reload    = start & ((state == ST_DONE) | (state == ST_ERR));
  assign n_new     = {len_hi, bus.in_data};
  assign n_bad     = (n_new == 16'd0) || (32'(n_new) > max_words(ADDR_W));
  assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .clr        (!rst || reload),
    .shift      (xfer && (state == ST_DATA)),
    .byte_in    (bus.in_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_LEN_HI;
      len_hi         <= '0;
      len            <= '0;
      word_cnt       <= '0;
      bus.in_ready   <= 1'b1;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rst        <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.in_data;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len      <= n_new;
            word_cnt <= '0;
            if (n_bad) begin
              state        <= ST_ERR;
              bus.in_ready <= 1'b0;
              err          <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (pk_valid) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_cnt[ADDR_W-1:0];
            bus.imem_wdata <= pk_word;
            word_cnt       <= word_cnt + 1'b1;
            if (last_word) begin
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            len_hi       <= '0;
            len          <= '0;
            word_cnt     <= '0;
            bus.in_ready <= 1'b1;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
          end else if (state == ST_DONE) begin
            // Released one cycle after done so the final write has landed first.
            cpu_rst <= 1'b0;
          end
        end
        default: begin
          state        <= ST_ERR;
          bus.in_ready <= 1'b0;
          err          <= 1'b1;
          cpu_rst      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed and randomized frames against a word-list reference model
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rst, done, err;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_addr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (g) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clk);
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic send_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++) send_byte(frame[i], max_gap);
  endtask

  task automatic make_random_frame(input int n);
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
  endtask

  task automatic reload();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_err", 32'(err), 32'd0);
    chk("reload_in_ready", 32'(bus.in_ready), 32'd1);
    clear_log();
  endtask

  // Reference: length header decides ok/err; each group of four bytes is one big-endian word at its index.
  task automatic expect_frame(input string tag);
    int n;
    logic [31:0] w;
    n = int'({frame[0], frame[1]});
    repeat (3) @(negedge clk);
    if (n == 0 || n > CAP) begin
      chk($sformatf("%s_err", tag), 32'(err), 32'd1);
      chk($sformatf("%s_cpu_rst", tag), 32'(cpu_rst), 32'd1);
      chk($sformatf("%s_done", tag), 32'(done), 32'd0);
      chk($sformatf("%s_nwrites", tag), wr_addr_q.size(), 32'd0);
    end else begin
      chk($sformatf("%s_done", tag), 32'(done), 32'd1);
      chk($sformatf("%s_err", tag), 32'(err), 32'd0);
      chk($sformatf("%s_cpu_rst", tag), 32'(cpu_rst), 32'd0);
      chk($sformatf("%s_in_ready", tag), 32'(bus.in_ready), 32'd0);
      chk($sformatf("%s_nwrites", tag), wr_addr_q.size(), n);
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
        w = {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]};
        chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), i);
        chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], w);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Basic load with exact release timing
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
    clear_log();
    send_range(0, frame.size(), 0);
    chk("basic_we_last", 32'(bus.imem_we), 32'd1);
    chk("basic_done_at_last_write", 32'(done), 32'd1);
    chk("basic_cpu_rst_held", 32'(cpu_rst), 32'd1);
    chk("basic_wdata_last", bus.imem_wdata, 32'h0000002A);
    @(negedge clk);
    chk("basic_cpu_rst_release", 32'(cpu_rst), 32'd0);
    chk("basic_we_single", 32'(bus.imem_we), 32'd0);
    chk("basic_addr_hold", 32'(bus.imem_addr), 32'd1);
    chk("basic_wdata_hold", bus.imem_wdata, 32'h0000002A);
    expect_frame("basic");

    // Same stream with bubbles
    reload();
    send_range(0, frame.size(), 5);
    expect_frame("bubbles");

    // Random frames, random gaps
    for (int k = 0; k < 4; k++) begin
      reload();
      make_random_frame(int'($urandom_range(8, 1)));
      send_range(0, frame.size(), int'($urandom_range(3, 0)));
      expect_frame($sformatf("rand%0d", k));
    end

    // start during DATA has no effect
    reload();
    make_random_frame(3);
    send_range(0, 6, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_data_in_ready", 32'(bus.in_ready), 32'd1);
    send_range(6, frame.size(), 1);
    expect_frame("start_in_data");

    // Zero length, then bytes must be refused
    reload();
    frame = '{8'h00, 8'h00};
    send_range(0, 2, 0);
    expect_frame("zero_len");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
      chk("zero_len_refuse", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("zero_len_nwrites_after", wr_addr_q.size(), 32'd0);
    chk("zero_len_err_after", 32'(err), 32'd1);

    // Over capacity
    reload();
    frame = '{8'h01, 8'h01};
    send_range(0, 2, 0);
    expect_frame("over_cap");

    // Exactly full capacity
    reload();
    make_random_frame(CAP);
    send_range(0, frame.size(), 0);
    expect_frame("full_cap");
    chk("full_cap_last_addr", (wr_addr_q.size() > 0) ? 32'(wr_addr_q[$]) : 32'hFFFF_FFFF, 32'h000000FF);

    // Reset during a partial word
    reload();
    frame = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send_range(0, 4, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_we", 32'(bus.imem_we), 32'd0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_nwrites", wr_addr_q.size(), 32'd0);
    frame = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    send_range(0, frame.size(), 0);
    expect_frame("after_midrst");
    chk("after_midrst_word", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the instruction memory of the single-cycle MIPS core.
- Accepts a framed byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes those words sequentially into instruction memory starting at word address 0.
- Holds the processor in reset until the load completes, then releases it so execution starts at pc 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- start  input  1  reload request; honoured only in DONE or ERR
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  word to write
- cpu_rst  output  1  active-high reset to the processor
- done  output  1  load completed successfully
- err  output  1  malformed frame

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset (rst==0 at a clk edge):
  - state=LEN_HI; byte counter, word counter and length register cleared.
  - in_ready=1 from the first cycle after reset; imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, done=0, err=0.
- Frame format:
  - 16-bit big-endian word count N: high byte first.
  - Then N*4 data bytes. Each word is big-endian: first byte goes to [31:24], last to [7:0].
- Handshake: a byte transfers on a clk edge where in_valid & in_ready. in_data is ignored otherwise. The source may insert bubbles freely.
- FSM states: LEN_HI, LEN_LO, DATA, DONE, ERR.
  - LEN_HI: in_ready=1. On transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer, latch N[7:0].
    - If N==0 or N>2^ADDR_W, go to ERR.
    - Otherwise go to DATA with word_cnt=0 and byte_cnt=0.
  - DATA: in_ready=1.
    - Each transfer shifts the byte into the packer and increments byte_cnt (mod 4).
    - On the 4th byte (cycle t), at t+1: imem_we=1, imem_addr=word_cnt[ADDR_W-1:0], imem_wdata=packed word. word_cnt increments.
    - Back-to-back bytes are accepted while the write is presented; there is no throughput loss.
    - If that word is word N-1, the state becomes DONE at t+1.
  - DONE: in_ready=0, done=1. cpu_rst falls at t+2, one cycle after the final imem_we.
  - ERR: in_ready=0, err=1, cpu_rst=1. No further writes.
- imem_we is high for exactly one cycle per word and low in every other cycle.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Counters: word_cnt is ADDR_W+1 bits wide, compared against N. N=2^ADDR_W is legal; the last address is 2^ADDR_W-1, with no wrap.
- start:
  - Honoured in DONE or ERR: next state LEN_HI; done and err clear and cpu_rst rises on the following cycle; counters clear.
  - Ignored in LEN_HI, LEN_LO and DATA.
- Reset mid-operation:
  - Partial word and length are discarded; no write is issued for the partial word.
  - Words already written stay in memory.
  - cpu_rst=1 immediately after the reset edge.
- cpu_rst is 1 in every state except DONE (after the one-cycle delay).

Decomposition:
- Shared package:
  - FSM state enum: LEN_HI, LEN_LO, DATA, DONE, ERR.
  - LEN_BYTES=2, BYTES_PER_WORD=4.
  - Function max_words(ADDR_W).
- Natural sub-module: byte_packer.
  - Inputs: 8-bit byte and shift strobe.
  - Outputs: 32-bit big-endian word and a word_valid pulse on the 4th byte.
  - Clear input driven by reset or start.

Test Plan:
- Basic load:
  - Stimulus: stream 00 02 DE AD BE EF 00 00 00 2A with no gaps.
  - Required: writes addr0=0xDEADBEEF, then addr1=0x0000002A. done=1 on the cycle of the 2nd write; cpu_rst=0 the next cycle; in_ready=0 afterwards.
- Zero length:
  - Stimulus: stream 00 00.
  - Required: err=1, in_ready=0, cpu_rst=1, zero imem_we pulses. Further bytes are not accepted.
- Capacity limits (ADDR_W=8):
  - Stimulus: header 01 01 (257 words).
  - Required: err=1.
  - Stimulus: header 01 00 with 1024 bytes.
  - Required: 256 writes, last at addr 0xFF, then done=1.
- Bubbles:
  - Stimulus: the basic-load stream with random in_valid gaps of 0-5 cycles.
  - Required: identical write sequence, exactly one imem_we per word.
- Reset during a partial word:
  - Stimulus: rst=0 for one cycle after DE AD of word 0.
  - Required: state LEN_HI, no write issued, cpu_rst=1.
  - Stimulus: then a fresh 00 01 11 22 33 44.
  - Required: addr0=0x11223344.
- Reload:
  - Stimulus: pulse start in DONE.
  - Required: cpu_rst=1 and done=0 on the next cycle, in_ready=1; a new frame reloads from addr 0.
  - Stimulus: start pulsed during DATA.
  - Required: no effect.
